// File: rtl/spmc_pkg.sv
// spmc_pkg: register offsets, STATUS bit positions and bridge state encodings
package spmc_pkg;
    localparam int OFF_CTRL    = 0;
    localparam int OFF_STATUS  = 1;
    localparam int OFF_CMD     = 2;
    localparam int OFF_ID      = 3;
    localparam int OFF_CH_BASE = 4;
    localparam int ST_READY    = 0;
    localparam int ST_OVF      = 1;
    localparam int ST_ERR_BUSY = 2;
    localparam int ST_ERR_ADDR = 3;
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOADING = 2'd1,
        S_RUNNING = 2'd2
    } state_t;
endpackage

// File: rtl/spmc_gran_ptr.sv
// spmc_gran_ptr: per-channel granule write pointer with range-checked load and wrapping increment
module spmc_gran_ptr #(
    parameter int DATA_W      = 18,
    parameter int GRAN_ADDR_W = 10,
    parameter int GRAN_DEPTH  = 576
) (
    input  logic                   clk_peri,
    input  logic                   reset,
    input  logic                   load,
    input  logic [DATA_W-1:0]      load_val,
    input  logic                   inc,
    output logic [GRAN_ADDR_W-1:0] ptr,
    output logic                   wrap,
    output logic                   addr_err
);
    assign wrap     = inc && ptr == GRAN_ADDR_W'(GRAN_DEPTH - 1);
    assign addr_err = load && load_val >= DATA_W'(GRAN_DEPTH);

    // out-of-range loads leave the pointer alone; increments wrap at the last entry
    always_ff @(posedge clk_peri) begin
        if (reset)
            ptr <= '0;
        else if (load && !addr_err)
            ptr <= load_val[GRAN_ADDR_W-1:0];
        else if (inc)
            ptr <= wrap ? '0 : ptr + GRAN_ADDR_W'(1);
    end
endmodule

// File: rtl/spmc_reg_bridge.sv
// spmc_reg_bridge: peripheral register front end loading granule memories and starting the decode chain
module spmc_reg_bridge #(
    parameter logic [9:0] BASE_ADR    = 10'h000,
    parameter int         CHANNELS    = 2,
    parameter int         DATA_W      = 18,
    parameter int         GRAN_ADDR_W = 10,
    parameter int         GRAN_DEPTH  = 576
) (
    input  logic                            clk_peri,
    input  logic                            reset,
    input  logic [DATA_W-1:0]               do_peri,
    output logic [DATA_W-1:0]               di_peri,
    input  logic [9:0]                      addr_peri,
    input  logic                            access_peri,
    input  logic                            wr_peri,
    output logic [CHANNELS-1:0]             gran_we,
    output logic [CHANNELS*GRAN_ADDR_W-1:0] gran_addr,
    output logic [DATA_W-1:0]               gran_data,
    input  logic                            stage_ready,
    output logic                            stage_done,
    output logic                            irq
);
    import spmc_pkg::*;

    localparam int NREG = OFF_CH_BASE + 2 * CHANNELS;

    logic [9:0]             off;
    logic                   borrow, hit, wr, rd, running, cmd_wr, status_rd, busy_err, irq_en;
    logic [3:0]             flags, flag_set;
    logic [CHANNELS-1:0]    addr_wr, data_wr, data_acc, wrap, addr_err;
    logic [GRAN_ADDR_W-1:0] ptr [CHANNELS];
    state_t                 state;

    assign {borrow, off} = {1'b0, addr_peri} - {1'b0, BASE_ADR};
    assign hit       = access_peri && !borrow && off < 10'(NREG);
    assign wr        = hit && wr_peri;
    assign rd        = hit && !wr_peri;
    assign running   = state == S_RUNNING;
    assign cmd_wr    = wr && off == 10'(OFF_CMD);
    assign status_rd = rd && off == 10'(OFF_STATUS);
    assign busy_err  = running && (cmd_wr || |data_wr);
    assign data_acc  = running ? '0 : data_wr;
    assign irq       = irq_en && |flags;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        assign addr_wr[c] = wr && off == 10'(OFF_CH_BASE + 2 * c);
        assign data_wr[c] = wr && off == 10'(OFF_CH_BASE + 2 * c + 1);
        spmc_gran_ptr #(
            .DATA_W     (DATA_W),
            .GRAN_ADDR_W(GRAN_ADDR_W),
            .GRAN_DEPTH (GRAN_DEPTH)
        ) u_ptr (
            .clk_peri(clk_peri),
            .reset   (reset),
            .load    (addr_wr[c]),
            .load_val(do_peri),
            .inc     (data_acc[c]),
            .ptr     (ptr[c]),
            .wrap    (wrap[c]),
            .addr_err(addr_err[c])
        );
    end

    // events that raise each sticky status flag this cycle
    always_comb begin
        flag_set              = '0;
        flag_set[ST_READY]    = stage_ready;
        flag_set[ST_OVF]      = |(data_acc & wrap);
        flag_set[ST_ERR_BUSY] = busy_err;
        flag_set[ST_ERR_ADDR] = |(addr_wr & addr_err);
    end

    // read mux: only a decoded read drives the bus, write-only offsets read zero
    always_comb begin
        di_peri = '0;
        if (rd) begin
            if (off == 10'(OFF_CTRL))   di_peri = DATA_W'(irq_en);
            if (off == 10'(OFF_STATUS)) di_peri = DATA_W'({state, flags});
            if (off == 10'(OFF_ID))     di_peri = DATA_W'(CHANNELS);
            for (int c = 0; c < CHANNELS; c++)
                if (off == 10'(OFF_CH_BASE + 2 * c)) di_peri = DATA_W'(ptr[c]);
        end
    end

    // control register and sticky flags; a same-cycle set survives the STATUS read clear
    always_ff @(posedge clk_peri) begin
        if (reset) begin
            irq_en <= 1'b0;
            flags  <= '0;
        end else begin
            if (wr && off == 10'(OFF_CTRL)) irq_en <= do_peri[0];
            flags <= flag_set | (status_rd ? 4'b0 : flags);
        end
    end

    // load/run state machine with registered granule write port and start pulse
    always_ff @(posedge clk_peri) begin
        if (reset) begin
            state      <= S_IDLE;
            stage_done <= 1'b0;
            gran_we    <= '0;
            gran_addr  <= '0;
            gran_data  <= '0;
        end else begin
            stage_done <= cmd_wr && !running;
            gran_we    <= data_acc;
            if (|data_acc) gran_data <= do_peri;
            for (int c = 0; c < CHANNELS; c++)
                if (data_acc[c]) gran_addr[c*GRAN_ADDR_W +: GRAN_ADDR_W] <= ptr[c];
            if (running) begin
                if (stage_ready) state <= S_IDLE;
            end else if (cmd_wr)
                state <= S_RUNNING;
            else if (|data_acc && state == S_IDLE)
                state <= S_LOADING;
        end
    end
endmodule

// File: doc/spmc_reg_bridge.md
Name: spmc_reg_bridge

Overview:
- Parametrised peripheral-bus front end for the decoding chain. Generalises the fixed single-stereo register set to CHANNELS granule memories.
- Each channel has an auto-incrementing write pointer, so a host loads a granule by writing DATA repeatedly after a single ADDR write.
- Adds a load/run state machine with busy protection, sticky status flags (clear-on-read) and a maskable interrupt.
- Sits between the peripheral bus (clk_peri domain) and the chain's granule write ports and stage_ready/stage_done handshake.

Parameters:
- BASE_ADR, 10'h000, first peripheral address of the block.
- CHANNELS, 2, number of granule channels (1..4).
- DATA_W, 18, bus and granule data width.
- GRAN_ADDR_W, 10, granule pointer width.
- GRAN_DEPTH, 576, valid granule entries; pointer range 0..GRAN_DEPTH-1.

Ports:
- clk_peri, input, 1, peripheral clock.
- reset, input, 1, synchronous, active-high.
- do_peri, input, DATA_W, bus write data.
- di_peri, output, DATA_W, bus read data.
- addr_peri, input, 10, bus address.
- access_peri, input, 1, bus access strobe (one cycle per access).
- wr_peri, input, 1, 1 = write, 0 = read.
- gran_we, output, CHANNELS, per-channel granule write strobe.
- gran_addr, output, CHANNELS*GRAN_ADDR_W, per-channel granule write address; channel c occupies slice [c*GRAN_ADDR_W +: GRAN_ADDR_W].
- gran_data, output, DATA_W, granule write data, shared by all channels.
- stage_ready, input, 1, chain pulse meaning the chain has finished and can take a new granule.
- stage_done, output, 1, one-cycle pulse that starts the chain.
- irq, output, 1, interrupt request.

Behaviour:
- Decode. hit = access_peri and BASE_ADR <= addr_peri < BASE_ADR+4+2*CHANNELS. off = addr_peri-BASE_ADR.
- Register map:
  - off 0: CTRL (rw). bit0 = irq_en.
  - off 1: STATUS (ro, clear-on-read). bit0 = ready, bit1 = ovf, bit2 = err_busy, bit3 = err_addr, bits5:4 = state.
  - off 2: CMD (wo). Any write requests the start of a run.
  - off 3: ID (ro). Reads CHANNELS.
  - off 4+2c: ADDR_c (rw).
  - off 5+2c: DATA_c (wo).
- Read path:
  - di_peri is combinational from registered state whenever hit and not wr_peri; otherwise 0.
  - Unused bits read 0.
  - Write-only registers read 0.
- State machine (2-bit): IDLE=0, LOADING=1, RUNNING=2.
  - IDLE -> LOADING on the first accepted DATA write.
  - IDLE or LOADING -> RUNNING on a CMD write; stage_done pulses high in the next cycle for exactly one cycle.
  - RUNNING -> IDLE on stage_ready.
- DATA_c write (state not RUNNING):
  - Next cycle: gran_we[c]=1, gran_addr slice c = pointer value before the write, gran_data = do_peri.
  - The pointer increments on the same edge.
  - If the pointer was GRAN_DEPTH-1, it wraps to 0 and ovf is set.
- DATA_c write in RUNNING: dropped (no gran_we) and err_busy set.
- CMD write in RUNNING: ignored and err_busy set.
- ADDR_c write:
  - If do_peri < GRAN_DEPTH, the pointer loads do_peri[GRAN_ADDR_W-1:0].
  - Otherwise the pointer is unchanged and err_addr set.
  - Allowed in any state.
  - ADDR_c read returns the current pointer.
- gran_we is high for one cycle per accepted DATA write only. gran_addr and gran_data hold their values between writes.
- Sticky flags:
  - The ready flag is set by every stage_ready pulse, in any state.
  - A STATUS read returns the pre-clear values and clears all four flags on that edge.
  - Set wins over clear: a flag-setting event in the same cycle as a STATUS read leaves that flag at 1.
- Simultaneous stage_ready and CMD write in RUNNING: stage_ready takes precedence, so state -> IDLE and ready is set. The CMD is treated as busy: it is ignored and err_busy is set.
- irq = irq_en and (ready or ovf or err_busy or err_addr). Purely combinational from registers.
- Reset values:
  - All pointers 0, all flags 0, CTRL 0, state IDLE.
  - Outputs: gran_we 0, gran_addr 0, gran_data 0, stage_done 0, irq 0.
  - Reset mid-load or mid-run aborts without any stage_done pulse.
- Accesses outside the decoded range have no effect.

Decomposition:
- Shared package spmc_pkg holds:
  - Register offset constants (OFF_CTRL, OFF_STATUS, OFF_CMD, OFF_ID, OFF_CH_BASE).
  - STATUS bit index constants.
  - State encodings.
- One sub-module, spmc_gran_ptr: per-channel pointer with load, increment, wrap and error outputs. Instantiated CHANNELS times in a generate loop.

Test Plan:
- Reset, then read ID and STATUS -> ID=2; STATUS=0; irq=0; gran_we=0.
- Write ADDR_1=10, then DATA_1 = 18'h3FFFF, 18'h00001 -> gran_we[1] pulses at addresses 10 and 11 with those data values; ADDR_1 reads 12; gran_we[0] never asserts.
- Write ADDR_0=575, then two DATA_0 writes -> addresses 575 then 0; STATUS bit1=1; a second STATUS read returns 0.
- Write ADDR_0=600 -> pointer unchanged; err_addr=1; with CTRL=1, irq=1 until STATUS is read.
- Write CMD -> one-cycle stage_done; state RUNNING. A DATA_0 write then produces no gran_we and sets err_busy. Pulse stage_ready -> state IDLE, ready=1.
- Assert stage_ready in the same cycle as a STATUS read -> the read returns ready=0 and the flag remains 1 afterwards. Assert reset while RUNNING -> all outputs and flags are 0 and no stage_done pulse occurs.
